// File: rtl/ov7670_pixel_writer.sv
// OV7670 write-side producer: pairs RGB565 bytes into 16-bit FIFO words,
// gates frames on vsync and lines on href, tracks geometry and overflow.
//
// Ports:
//   clk_write    camera PCLK, all logic on posedge
//   rst_n        async active-low reset
//   enable       capture enable, acted on only at frame boundaries
//   cam_vsync    camera vsync (PCLK-synchronous), polarity set by VSYNC_POL
//   cam_href     camera href, high during active bytes
//   cam_d        camera data byte
//   full         FIFO full (write-domain registered)
//   write        FIFO write strobe, one cycle per word
//   data_write   RGB565 word {first byte, second byte}
//   frame_active high while capturing
//   frame_done   one-cycle pulse at end of each captured frame
//   line_cnt     lines completed in the current frame (saturating)
//   size_err     last frame's geometry differed from H_ACTIVE x V_ACTIVE
//   drop_cnt     saturating count of words lost to full
module ov7670_pixel_writer #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter bit VSYNC_POL  = 1'b1,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk_write,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  cam_vsync,
    input  logic                  cam_href,
    input  logic [7:0]            cam_d,
    input  logic                  full,
    output logic                  write,
    output logic [15:0]           data_write,
    output logic                  frame_active,
    output logic                  frame_done,
    output logic [9:0]            line_cnt,
    output logic                  size_err,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    // One spare bit so the saturated pixel count can never equal H_ACTIVE.
    localparam int PW = $clog2(H_ACTIVE + 2) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CAP,
        S_END
    } state_t;

    state_t                  state_q, state_d;
    logic                    vs_q;
    logic                    href_q;
    logic                    phase_q, phase_d;
    logic [7:0]              hi_q, hi_d;
    logic [PW-1:0]           pix_q, pix_d;
    logic [9:0]              line_q, line_d;
    logic                    lerr_q, lerr_d;
    logic                    serr_q, serr_d;
    logic                    wr_q, wr_d;
    logic [15:0]             dw_q, dw_d;
    logic [DROP_CNT_W-1:0]   drop_q, drop_d;

    logic vs;
    logic vs_fall;
    logic vs_rise;
    logic href_fall;

    assign vs        = cam_vsync ^ ~VSYNC_POL;
    assign vs_fall   = vs_q & ~vs;
    assign vs_rise   = ~vs_q & vs;
    assign href_fall = href_q & ~cam_href;

    always_ff @(posedge clk_write or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vs_q    <= 1'b0;
            href_q  <= 1'b0;
            phase_q <= 1'b0;
            hi_q    <= 8'h00;
            pix_q   <= '0;
            line_q  <= 10'd0;
            lerr_q  <= 1'b0;
            serr_q  <= 1'b0;
            wr_q    <= 1'b0;
            dw_q    <= 16'h0000;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            vs_q    <= vs;
            href_q  <= cam_href;
            phase_q <= phase_d;
            hi_q    <= hi_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
            lerr_q  <= lerr_d;
            serr_q  <= serr_d;
            wr_q    <= wr_d;
            dw_q    <= dw_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = 1'b0;
        hi_d    = hi_q;
        pix_d   = pix_q;
        line_d  = line_q;
        lerr_d  = lerr_q;
        serr_d  = serr_q;
        wr_d    = 1'b0;
        dw_d    = dw_q;
        drop_d  = drop_q;

        unique case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (vs_fall) begin
                    state_d = S_CAP;
                    line_d  = 10'd0;
                    pix_d   = '0;
                    lerr_d  = 1'b0;
                end
            end
            S_CAP: begin
                if (cam_href) begin
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        hi_d = cam_d;
                    end else begin
                        // Geometry counts every word, written or dropped.
                        if (pix_q != '1) pix_d = pix_q + 1'b1;
                        if (full) begin
                            if (drop_q != '1) drop_d = drop_q + 1'b1;
                        end else begin
                            wr_d = 1'b1;
                            dw_d = {hi_q, cam_d};
                        end
                    end
                end
                if (href_fall) begin
                    if (line_q != 10'h3FF) line_d = line_q + 10'd1;
                    // A dangling odd byte also marks the line bad.
                    if (pix_q != PW'(H_ACTIVE) || phase_q) lerr_d = 1'b1;
                    pix_d = '0;
                end
                if (vs_rise) begin
                    state_d = S_END;
                    if (cam_href) lerr_d = 1'b1;
                end
            end
            S_END: begin
                serr_d  = (line_q != 10'(V_ACTIVE)) | lerr_q;
                state_d = enable ? S_WAIT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign write        = wr_q;
    assign data_write   = dw_q;
    assign frame_active = (state_q == S_CAP);
    assign frame_done   = (state_q == S_END);
    assign line_cnt     = line_q;
    assign size_err     = serr_q;
    assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_ov7670_pixel_writer.sv
// Directed bench for ov7670_pixel_writer with a 4x2 frame geometry
// and a 4-bit drop counter.
module tb_ov7670_pixel_writer;

    logic        clk_write = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_d = 8'h00;
    logic        full = 1'b0;
    logic        write;
    logic [15:0] data_write;
    logic        frame_active;
    logic        frame_done;
    logic [9:0]  line_cnt;
    logic        size_err;
    logic [3:0]  drop_cnt;

    int total = 0;
    int bad = 0;
    int n_done = 0;
    logic [7:0]  nb = 8'h12;
    logic [7:0]  hi = 8'h00;
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];

    ov7670_pixel_writer #(
        .H_ACTIVE(4),
        .V_ACTIVE(2),
        .VSYNC_POL(1'b1),
        .DROP_CNT_W(4)
    ) dut (
        .clk_write(clk_write),
        .rst_n(rst_n),
        .enable(enable),
        .cam_vsync(cam_vsync),
        .cam_href(cam_href),
        .cam_d(cam_d),
        .full(full),
        .write(write),
        .data_write(data_write),
        .frame_active(frame_active),
        .frame_done(frame_done),
        .line_cnt(line_cnt),
        .size_err(size_err),
        .drop_cnt(drop_cnt)
    );

    always #5 clk_write = ~clk_write;

    always @(negedge clk_write) begin
        if (rst_n) begin
            if (write) got_q.push_back(data_write);
            if (frame_done) n_done++;
        end
    end

    task automatic tick();
        @(posedge clk_write);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_words(input string tag);
        chk({tag, "_nwr"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({tag, "_word"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_write"}, write, 0);
        chk({tag, "_data"}, data_write, 0);
        chk({tag, "_active"}, frame_active, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_lines"}, line_cnt, 0);
        chk({tag, "_serr"}, size_err, 0);
        chk({tag, "_drop"}, drop_cnt, 0);
    endtask

    task automatic vs_start();
        cam_vsync = 1'b1;
        repeat (3) tick();
        cam_vsync = 1'b0;
        repeat (2) tick();
    endtask

    task automatic vs_end();
        cam_vsync = 1'b1;
        repeat (4) tick();
    endtask

    task automatic send_line(input int nbytes, input logic f,
                             input logic lat);
        full = f;
        cam_href = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            cam_d = nb;
            if (i % 2 == 0) hi = nb;
            else if (!f) exp_q.push_back({hi, nb});
            nb = nb + 8'h22;
            tick();
            if (lat && i == 1) begin
                chk("lat_write", write, 1);
                chk("lat_data", data_write, 16'h1234);
            end
        end
        cam_href = 1'b0;
        repeat (3) tick();
        full = 1'b0;
    endtask

    task automatic clean_frame(input string tag);
        int d0;
        d0 = n_done;
        vs_start();
        chk({tag, "_active"}, frame_active, 1);
        send_line(8, 1'b0, 1'b0);
        send_line(8, 1'b0, 1'b0);
        vs_end();
        chk({tag, "_done"}, n_done - d0, 1);
        chk({tag, "_lines"}, line_cnt, 2);
        chk({tag, "_serr"}, size_err, 0);
        chk_words(tag);
    endtask

    initial begin
        int d0;
        repeat (3) tick();
        chk_reset("rst");
        rst_n = 1'b1;
        tick();

        // Clean frame; first word 0x1234 with one-cycle latency.
        enable = 1'b1;
        nb = 8'h12;
        tick();
        d0 = n_done;
        vs_start();
        chk("t1_active", frame_active, 1);
        send_line(8, 1'b0, 1'b1);
        send_line(8, 1'b0, 1'b0);
        vs_end();
        chk("t1_first", got_q.size() > 0 ? got_q[0] : 16'hxxxx, 16'h1234);
        chk("t1_done", n_done - d0, 1);
        chk("t1_lines", line_cnt, 2);
        chk("t1_serr", size_err, 0);
        chk("t1_idle", frame_active, 0);
        chk_words("t1");

        // Second line lost to full.
        vs_start();
        send_line(8, 1'b0, 1'b0);
        send_line(8, 1'b1, 1'b0);
        vs_end();
        chk("t2_drop", drop_cnt, 4);
        chk("t2_serr", size_err, 0);
        chk_words("t2");

        // Odd-length line, then recovery.
        vs_start();
        send_line(7, 1'b0, 1'b0);
        send_line(8, 1'b0, 1'b0);
        vs_end();
        chk("t3_serr", size_err, 1);
        chk("t3_lines", line_cnt, 2);
        chk_words("t3");
        clean_frame("t3b");

        // Disabled frame body, enable raised mid-vsync.
        enable = 1'b0;
        repeat (2) tick();
        cam_vsync = 1'b0;
        repeat (2) tick();
        send_line(8, 1'b0, 1'b0);
        send_line(8, 1'b0, 1'b0);
        chk("t4_nowr", got_q.size(), 0);
        exp_q.delete();
        got_q.delete();
        cam_vsync = 1'b1;
        repeat (2) tick();
        enable = 1'b1;
        repeat (2) tick();
        chk("t4_wait", frame_active, 0);
        cam_vsync = 1'b0;
        repeat (2) tick();
        chk("t4_active", frame_active, 1);
        send_line(8, 1'b0, 1'b0);
        send_line(8, 1'b0, 1'b0);
        vs_end();
        chk("t4_serr", size_err, 0);
        chk_words("t4");

        // Reset mid-line after a phase-0 byte.
        vs_start();
        cam_href = 1'b1;
        cam_d = 8'hA5;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("t5");
        cam_href = 1'b0;
        repeat (2) tick();
        chk("t5_nowr", got_q.size(), 0);
        rst_n = 1'b1;
        tick();
        got_q.delete();
        exp_q.delete();
        clean_frame("t5b");

        // Drop counter saturation.
        vs_start();
        send_line(20, 1'b1, 1'b0);
        chk("t6_drop10", drop_cnt, 10);
        send_line(20, 1'b1, 1'b0);
        chk("t6_drop_sat", drop_cnt, 15);
        vs_end();
        chk("t6_nowr", got_q.size(), 0);
        chk("t6_serr", size_err, 1);
        got_q.delete();
        clean_frame("t6b");
        chk("t6_hold", drop_cnt, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
